// File: rtl/full_adder_reg.sv
// +--------------------------------------------------------------------+
// | full_adder_reg : ripple-carry adder with registered and            |
// | combinational {carry, sum} outputs.  Revision 1.0                  |
// +--------------------------------------------------------------------+
`default_nettype none

module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum_c,
  output logic             Cout_c
);

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic             out_valid_d, out_valid_q;

  // Carry is held in a loop variable rather than a vector so the chain
  // is not seen as a combinational self-loop on a single signal.
  always_comb begin
    logic carry;
    carry = C;
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = A[i] ^ B[i] ^ carry;
      carry    = (A[i] & B[i]) | (A[i] & carry) | (B[i] & carry);
    end
    w_cout = carry;
  end

  assign Sum_c  = w_sum;
  assign Cout_c = w_cout;

  // Operands are only observed when qualified, so X on idle inputs cannot leak.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = w_sum;
      cout_d      = w_cout;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_reg.sv
// +--------------------------------------------------------------------+
// | tb_full_adder_reg : checks WIDTH=1 and WIDTH=8 instances against   |
// | an arithmetic reference.  Revision 1.0                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_full_adder_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv1, a1, b1, c1;
  logic       s1, co1, ov1, sc1, coc1;
  logic       iv8, c8;
  logic [7:0] a8, b8;
  logic [7:0] s8, sc8;
  logic       co8, ov8, coc8;

  full_adder_reg #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .C(c1),
    .Sum(s1), .Cout(co1), .out_valid(ov1), .Sum_c(sc1), .Cout_c(coc1)
  );

  full_adder_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .C(c8),
    .Sum(s8), .Cout(co8), .out_valid(ov8), .Sum_c(sc8), .Cout_c(coc8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: registered result is the integer sum of the last accepted operands.
  logic [8:0] m8;
  logic       m8v;
  logic [1:0] m1;
  logic       m1v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= '0; m8v <= 1'b0; m1 <= '0; m1v <= 1'b0;
    end else begin
      m8v <= iv8;
      m1v <= iv1;
      if (iv8) m8 <= 9'(a8) + 9'(b8) + 9'(c8);
      if (iv1) m1 <= 2'(a1) + 2'(b1) + 2'(c1);
    end
  end

  logic [8:0] exp_c8;
  logic [1:0] exp_c1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m8_sum",  64'(s8),  64'(m8[7:0]));
      chk("m8_cout", 64'(co8), 64'(m8[8]));
      chk("m8_ov",   64'(ov8), 64'(m8v));
      chk("m1_sum",  64'(s1),  64'(m1[0]));
      chk("m1_cout", 64'(co1), 64'(m1[1]));
      chk("m1_ov",   64'(ov1), 64'(m1v));
      if (!$isunknown({a8, b8, c8})) begin
        exp_c8 = 9'(a8) + 9'(b8) + 9'(c8);
        chk("m8_comb", 64'({coc8, sc8}), 64'(exp_c8));
      end
      if (!$isunknown({a1, b1, c1})) begin
        exp_c1 = 2'(a1) + 2'(b1) + 2'(c1);
        chk("m1_comb", 64'({coc1, sc1}), 64'(exp_c1));
      end
    end
  end

  task automatic step1(input logic a, input logic b, input logic c, input logic v);
    @(posedge clk); #1;
    a1 = a; b1 = b; c1 = c; iv1 = v;
  endtask

  task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    @(posedge clk); #1;
    a8 = a; b8 = b; c8 = c; iv8 = v;
  endtask

  // {Cout, Sum} for (A,B,C) = 000 .. 111
  logic [1:0] tbl1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [8:0] strm_exp [4] = '{9'h046, 9'h100, 9'h081, 9'h000};
  logic [7:0] strm_a [4] = '{8'h12, 8'h80, 8'h7F, 8'h00};
  logic [7:0] strm_b [4] = '{8'h34, 8'h80, 8'h01, 8'h00};
  logic       strm_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    iv1 = 0; a1 = 0; b1 = 0; c1 = 0;
    iv8 = 0; a8 = 0; b8 = 0; c8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum8",  64'(s8),  64'd0);
    chk("rst_cout8", 64'(co8), 64'd0);
    chk("rst_ov8",   64'(ov8), 64'd0);
    chk("rst_sum1",  64'(s1),  64'd0);
    chk("rst_ov1",   64'(ov1), 64'd0);
    rst_n = 1'b1;

    // WIDTH=1 truth table, one vector per cycle
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = 3'(k);
      step1(kv[2], kv[1], kv[0], 1'b1);
      @(negedge clk);
      chk("tt_comb", 64'({coc1, sc1}), 64'(tbl1[k]));
      if (k > 0) begin
        chk("tt_reg", 64'({co1, s1}), 64'(tbl1[k-1]));
        chk("tt_ov",  64'(ov1), 64'd1);
      end
    end
    step1(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("tt_reg_last", 64'({co1, s1}), 64'(tbl1[7]));

    // Hold: capture 1+1+0 then idle with different operands
    step1(1'b1, 1'b1, 1'b0, 1'b1);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_cap", 64'({ov1, co1, s1}), 64'b110);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_keep", 64'({ov1, co1, s1}), 64'b010);

    // Asynchronous reset between edges
    step1(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    iv1 = 1'b0;
    #1;
    chk("ar_before", 64'({ov1, co1, s1}), 64'b111);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_regs", 64'({ov1, co1, s1}), 64'b000);
    chk("ar_comb", 64'({coc1, sc1}), 64'b11);

    // Release reset with a valid operand already present on the same edge
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; iv8 = 1'b1;
    rst_n = 1'b1;
    step8(8'hFF, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    chk("rip_ff00", 64'({ov8, co8, s8}), 64'h300);
    step8(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("rip_ffff", 64'({ov8, co8, s8}), 64'h3FF);

    // Back-to-back stream
    for (int k = 0; k < 4; k++) begin
      step8(strm_a[k], strm_b[k], strm_c[k], 1'b1);
      @(negedge clk);
      if (k > 0) chk("strm", 64'({ov8, strm_exp[k-1]} ^ {ov8, co8, s8} ^ {1'b1, strm_exp[k-1]}), 64'({1'b1, strm_exp[k-1]}));
    end
    step8(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("strm_last", 64'({ov8, co8, s8}), 64'({1'b1, strm_exp[3]}));

    // Random, with X on idle operands
    for (int n = 0; n < 1000; n++) begin
      logic v;
      v = 1'($urandom_range(0, 3) != 0);
      step8(8'($urandom), 8'($urandom), 1'($urandom), v);
      if (!v && ($urandom_range(0, 3) == 0)) begin
        a8 = 'x; b8 = 'x; c8 = 'x;
      end
    end
    step8(8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/full_adder_reg.md
Name:
full_adder_reg

Overview:
- Registered full adder: adds operands A and B plus carry-in C, producing Sum and carry-out Cout.
- The datapath is a ripple chain of 1-bit full-adder cells, WIDTH bits wide. WIDTH=1 is the classic single-bit full adder.
- A zero-latency combinational result is also exported, so the block can sit in a carry chain or feed a pipeline stage.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A/B/C. When high, the inputs are captured on the clk rising edge.
- A  input  WIDTH  addend.
- B  input  WIDTH  addend.
- C  input  1  carry-in.
- Sum  output  WIDTH  registered sum bits.
- Cout  output  1  registered carry-out.
- out_valid  output  1  high for one cycle when Sum/Cout hold a newly captured result.
- Sum_c  output  WIDTH  combinational sum of the current A, B, C.
- Cout_c  output  1  combinational carry-out of the current A, B, C.

Behaviour:
- Arithmetic: {Cout_c, Sum_c} = A + B + C, computed at WIDTH+1 bits with no truncation.
- Bit cell i:
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i])
  - c[0] = C
  - Cout_c = c[WIDTH]
- Combinational outputs change within the same cycle as their inputs. They are independent of clk, rst_n and in_valid.
- Registered path, on each clk rising edge with rst_n=1:
  - If in_valid=1: Sum <= Sum_c, Cout <= Cout_c, out_valid <= 1.
  - If in_valid=0: Sum and Cout hold their previous values, out_valid <= 0.
- Latency: exactly 1 cycle from an in_valid=1 edge to the matching out_valid=1.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back out_valid pulses with no bubbles.
- Reset:
  - When rst_n falls, Sum=0, Cout=0 and out_valid=0 immediately, without waiting for clk.
  - This applies mid-operation: a result captured but not yet consumed is discarded.
  - Sum_c and Cout_c are unaffected by reset.
- Reset release:
  - The first capture happens on the first clk rising edge at which rst_n=1 and in_valid=1.
  - An in_valid asserted in the same cycle that reset deasserts is captured on that edge, provided rst_n is already high at the edge.
- No internal state other than Sum, Cout and out_valid.
- X on A, B or C while in_valid=0 must not disturb Sum or Cout.
- Wrap-around: the all-ones case is WIDTH ones plus ones plus carry 1. It must give Sum = all ones and Cout = 1.

Test Plan:
- WIDTH=1, reset released, in_valid=1, apply each combination of (A,B,C) from 000 to 111 for one cycle each:
  - Sum/Cout one cycle later must be 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
  - Sum_c/Cout_c must show the same values in the same cycle the inputs are applied.
- WIDTH=1, hold-and-valid: A=1, B=1, C=0 with in_valid=1 for one cycle, then in_valid=0 with A=0, B=0, C=1:
  - Sum=0 and Cout=1 must hold.
  - out_valid pulses exactly once, 1 cycle after capture.
- Async reset: capture A=1, B=1, C=1 (Sum=1, Cout=1), then pull rst_n low between clock edges:
  - Sum, Cout and out_valid go to 0 immediately.
  - Sum_c stays 1 and Cout_c stays 1.
- WIDTH=8, carry ripple: A=8'hFF, B=8'h00, C=1 -> Sum=8'h00, Cout=1. A=8'hFF, B=8'hFF, C=1 -> Sum=8'hFF, Cout=1.
- WIDTH=8, streaming: 4 consecutive valid inputs (0x12+0x34+0, 0x80+0x80+0, 0x7F+0x01+1, 0x00+0x00+0):
  - Results, one per cycle, must be 0x46/0, 0x00/1, 0x81/0, 0x00/0.
  - out_valid stays high for those 4 cycles.
- WIDTH=8, random: 1000 random (A, B, C, in_valid) vectors, checked against a reference of A+B+C delayed 1 cycle. Checking applies only when out_valid=1; Sum/Cout must otherwise hold.
